// File: rtl/addsub_pipe_pkg.sv
// Shared definitions for the pipelined adder/subtractor: op encodings,
// status flag bit order {N,Z,C,V} and small decode helpers.
package addsub_pipe_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_ADC = 2'b10,
      OP_SBC = 2'b11
   } op_e;

   localparam int NUM_FLAGS = 4;
   localparam int FLAG_N    = 3;
   localparam int FLAG_Z    = 2;
   localparam int FLAG_C    = 1;
   localparam int FLAG_V    = 0;

   typedef logic [NUM_FLAGS-1:0] flags_t;

   // Subtracting forms add the one's complement of b.
   function automatic logic op_inverts_b(input op_e op_v);
      return (op_v == OP_SUB) || (op_v == OP_SBC);
   endfunction

   function automatic logic op_carry_in(input op_e op_v, input logic cin_v);
      logic c;
      case (op_v)
         OP_ADD:  c = 1'b0;
         OP_SUB:  c = 1'b1;
         default: c = cin_v;
      endcase
      return c;
   endfunction

   function automatic flags_t pack_flags(input logic n, input logic z,
                                         input logic c, input logic v);
      flags_t f;
      f         = '0;
      f[FLAG_N] = n;
      f[FLAG_Z] = z;
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/addsub_pipe_slice.sv
// CHUNK-bit ripple-carry adder slice built from per-bit full-add equations.
module addsub_slice #(
   parameter int CHUNK = 4
) (
   input  logic             ci,
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   output logic [CHUNK-1:0] s,
   output logic             co
);

   logic [CHUNK:0] c;

   assign c[0] = ci;

   for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
      assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
   end

   assign co = c[CHUNK];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement add/sub: one CHUNK-bit slice resolved per stage,
// carry registered between stages, NZCV flags registered with the result.
module addsub_pipe
   import addsub_pipe_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_n,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v
);

   localparam int STAGES = WIDTH / CHUNK;
   localparam int LAST   = STAGES - 1;
   localparam int NREG   = (STAGES > 1) ? STAGES - 1 : 1;

   if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_params
      $error("addsub_pipe: WIDTH must be a positive multiple of CHUNK");
   end

   op_e              op_sel;
   logic [WIDTH-1:0] b_eff;
   logic             carry0;
   logic             adv;

   assign op_sel = op_e'(op);
   assign b_eff  = op_inverts_b(op_sel) ? ~b : b;
   assign carry0 = op_carry_in(op_sel, cin);

   // Per-stage combinational view. Operand vectors are kept right-aligned so
   // the slice a stage consumes is always bits [CHUNK-1:0].
   logic [WIDTH-1:0] src_a    [STAGES];
   logic [WIDTH-1:0] src_b    [STAGES];
   logic [WIDTH-1:0] part_in  [STAGES];
   logic [WIDTH-1:0] part_out [STAGES];
   logic             src_ci   [STAGES];
   logic             src_vld  [STAGES];
   logic [CHUNK-1:0] sl_s     [STAGES];
   logic             sl_co    [STAGES];

   // Inter-stage registers (between stage k and k+1).
   logic [WIDTH-1:0] a_d    [NREG];
   logic [WIDTH-1:0] a_q    [NREG];
   logic [WIDTH-1:0] b_d    [NREG];
   logic [WIDTH-1:0] b_q    [NREG];
   logic [WIDTH-1:0] part_d [NREG];
   logic [WIDTH-1:0] part_q [NREG];
   logic             cy_d   [NREG];
   logic             cy_q   [NREG];
   logic             vld_d  [NREG];
   logic             vld_q  [NREG];

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_src_in
         assign src_a[gi]   = a;
         assign src_b[gi]   = b_eff;
         assign src_ci[gi]  = carry0;
         assign src_vld[gi] = in_valid;
         assign part_in[gi] = '0;
      end else begin : g_src_reg
         assign src_a[gi]   = a_q[gi-1];
         assign src_b[gi]   = b_q[gi-1];
         assign src_ci[gi]  = cy_q[gi-1];
         assign src_vld[gi] = vld_q[gi-1];
         assign part_in[gi] = part_q[gi-1];
      end

      addsub_slice #(
         .CHUNK (CHUNK)
      ) u_slice (
         .ci (src_ci[gi]),
         .a  (src_a[gi][CHUNK-1:0]),
         .b  (src_b[gi][CHUNK-1:0]),
         .s  (sl_s[gi]),
         .co (sl_co[gi])
      );

      // Slice gi of the partial result is still zero here, so OR inserts it.
      assign part_out[gi] = part_in[gi] | (WIDTH'(sl_s[gi]) << (gi * CHUNK));

      if (gi < LAST) begin : g_next
         assign a_d[gi]    = src_a[gi] >> CHUNK;
         assign b_d[gi]    = src_b[gi] >> CHUNK;
         assign part_d[gi] = part_out[gi];
         assign cy_d[gi]   = sl_co[gi];
         assign vld_d[gi]  = src_vld[gi];
      end
   end

   if (STAGES == 1) begin : g_single
      assign a_d[0]    = '0;
      assign b_d[0]    = '0;
      assign part_d[0] = '0;
      assign cy_d[0]   = 1'b0;
      assign vld_d[0]  = 1'b0;
   end

   // Output stage: after the last slice the sign bits sit at CHUNK-1.
   logic [WIDTH-1:0] result_d, result_q;
   flags_t           flags_d, flags_q;
   logic             out_valid_d, out_valid_q;
   logic             a_msb, b_msb;

   assign result_d    = part_out[LAST];
   assign out_valid_d = src_vld[LAST];
   assign a_msb       = src_a[LAST][CHUNK-1];
   assign b_msb       = src_b[LAST][CHUNK-1];
   assign flags_d     = pack_flags(result_d[WIDTH-1],
                                   result_d == '0,
                                   sl_co[LAST],
                                   (a_msb == b_msb) && (result_d[WIDTH-1] != a_msb));

   assign adv      = !out_valid_q || out_ready;
   assign in_ready = adv;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
         for (int i = 0; i < NREG; i++) begin
            vld_q[i] <= 1'b0;
         end
      end else if (adv) begin
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
         for (int i = 0; i < NREG; i++) begin
            vld_q[i]  <= vld_d[i];
            cy_q[i]   <= cy_d[i];
            a_q[i]    <= a_d[i];
            b_q[i]    <= b_d[i];
            part_q[i] <= part_d[i];
         end
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign flag_n    = flags_q[FLAG_N];
   assign flag_z    = flags_q[FLAG_Z];
   assign flag_c    = flags_q[FLAG_C];
   assign flag_v    = flags_q[FLAG_V];

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe: an 8/4 instance and a 32/8 instance,
// expected results from an arithmetic reference model or fixed vectors.
module tb_addsub_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;

   logic        in_valid  [2];
   logic        in_ready  [2];
   logic        out_valid [2];
   logic        out_ready [2];
   logic        cin       [2];
   logic [1:0]  op        [2];
   logic [31:0] a         [2];
   logic [31:0] b         [2];
   logic [31:0] result    [2];
   logic [3:0]  flags     [2];

   logic [7:0]  res8;
   logic [31:0] res32;
   logic        n8, z8, c8, v8, n32, z32, c32, v32;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign result[0] = {24'h0, res8};
   assign result[1] = res32;
   assign flags[0]  = {n8, z8, c8, v8};
   assign flags[1]  = {n32, z32, c32, v32};

   addsub_pipe #(.WIDTH(8), .CHUNK(4)) u_dut8 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .a(a[0][7:0]), .b(b[0][7:0]), .op(op[0]), .cin(cin[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .result(res8), .flag_n(n8), .flag_z(z8), .flag_c(c8), .flag_v(v8)
   );

   addsub_pipe #(.WIDTH(32), .CHUNK(8)) u_dut32 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .a(a[1]), .b(b[1]), .op(op[1]), .cin(cin[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .result(res32), .flag_n(n32), .flag_z(z32), .flag_c(c32), .flag_v(v32)
   );

   typedef struct {
      logic [31:0] res;
      logic [3:0]  fl;
      int          cyc;
      bit          lat;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   function automatic int width_of(input int d);
      return (d == 0) ? 8 : 32;
   endfunction

   function automatic int stages_of(input int d);
      return (d == 0) ? 2 : 4;
   endfunction

   // Reference: true integer arithmetic, then reduce mod 2^w and classify.
   function automatic logic [35:0] model(input int w, input logic [31:0] av,
                                         input logic [31:0] bv, input logic [1:0] opv,
                                         input logic ci);
      longint modv, ua, ub, sa, sb, u, s, cv;
      logic [31:0] r;
      logic c, v;
      modv = longint'(1) << w;
      ua   = longint'(av) & (modv - 1);
      ub   = longint'(bv) & (modv - 1);
      sa   = (ua >= modv / 2) ? ua - modv : ua;
      sb   = (ub >= modv / 2) ? ub - modv : ub;
      cv   = ci ? 1 : 0;
      case (opv)
         2'b00:   begin u = ua + ub;          s = sa + sb;          c = (u >= modv); end
         2'b01:   begin u = ua - ub;          s = sa - sb;          c = (u >= 0);    end
         2'b10:   begin u = ua + ub + cv;     s = sa + sb + cv;     c = (u >= modv); end
         default: begin u = ua - ub - 1 + cv; s = sa - sb - 1 + cv; c = (u >= 0);    end
      endcase
      r = 32'(u & (modv - 1));
      v = (s >= modv / 2) || (s < -(modv / 2));
      return {r[w-1], (r == 32'h0), c, v, r};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   function automatic exp_t qpop(input int d);
      if (d == 0) return q0.pop_front();
      return q1.pop_front();
   endfunction

   task automatic send(input int d, input logic [31:0] av, input logic [31:0] bv,
                       input logic [1:0] opv, input logic ci, input bit use_k,
                       input logic [35:0] k, input bit lat);
      exp_t e;
      logic [35:0] m;
      bit ok;
      a[d] = av; b[d] = bv; op[d] = opv; cin[d] = ci; in_valid[d] = 1'b1;
      m  = use_k ? k : model(width_of(d), av, bv, opv, ci);
      ok = 1'b0;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         if (in_ready[d]) begin
            e.res = m[31:0]; e.fl = m[35:32]; e.cyc = cyc; e.lat = lat;
            if (d == 0) q0.push_back(e); else q1.push_back(e);
            ok = 1'b1;
         end
         @(posedge clk); #1;
      end
      if (!ok) chk("accept_timeout", 64'(in_ready[d]), 64'd1);
   endtask

   task automatic rand_send(input int d, input bit lat);
      logic [31:0] mask;
      mask = (d == 0) ? 32'hFF : 32'hFFFF_FFFF;
      send(d, $urandom & mask, $urandom & mask, 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'b0, 36'h0, lat);
   endtask

   // Monitor: pops on every consumed output; checks stability under stall.
   logic [31:0] hold_res [2];
   logic [3:0]  hold_fl  [2];
   bit          held     [2];

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst || !out_valid[d]) begin
            held[d] = 1'b0;
         end else begin
            if (held[d]) begin
               chk($sformatf("hold_result%0d", d), 64'(result[d]), 64'(hold_res[d]));
               chk($sformatf("hold_flags%0d", d), 64'(flags[d]), 64'(hold_fl[d]));
            end
            if (out_ready[d]) begin
               held[d] = 1'b0;
               if (qsize(d) == 0) begin
                  chk($sformatf("unexpected_out%0d", d), 64'(out_valid[d]), 64'd0);
               end else begin
                  exp_t e;
                  e = qpop(d);
                  $display("dut%0d out result=0x%0h nzcv=%b exp=0x%0h/%b", d,
                           result[d], flags[d], e.res, e.fl);
                  chk($sformatf("result%0d", d), 64'(result[d]), 64'(e.res));
                  chk($sformatf("flags%0d", d), 64'(flags[d]), 64'(e.fl));
                  if (e.lat)
                     chk($sformatf("latency%0d", d), 64'(cyc - e.cyc), 64'(stages_of(d)));
               end
            end else begin
               held[d]     = 1'b1;
               hold_res[d] = result[d];
               hold_fl[d]  = flags[d];
               chk($sformatf("stall_in_ready%0d", d), 64'(in_ready[d]), 64'd0);
            end
         end
      end
   end

   task automatic reset_with_inflight(input int d);
      rand_send(d, 1'b0);
      rand_send(d, 1'b0);
      in_valid[d] = 1'b0;
      rst = 1'b1;
      q0.delete();
      q1.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk($sformatf("rst_out_valid%0d", d), 64'(out_valid[d]), 64'd0);
      chk($sformatf("rst_result%0d", d), 64'(result[d]), 64'd0);
      chk($sformatf("rst_flags%0d", d), 64'(flags[d]), 64'd0);
      chk($sformatf("rst_in_ready%0d", d), 64'(in_ready[d]), 64'd1);
      repeat (8) @(posedge clk);
      #1;
      rand_send(d, 1'b1);
      in_valid[d] = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         in_valid[d] = 1'b0; out_ready[d] = 1'b1; cin[d] = 1'b0;
         op[d] = 2'b00; a[d] = '0; b[d] = '0;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("reset_out_valid%0d", d), 64'(out_valid[d]), 64'd0);
         chk($sformatf("reset_result%0d", d), 64'(result[d]), 64'd0);
         chk($sformatf("reset_flags%0d", d), 64'(flags[d]), 64'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++)
         chk($sformatf("post_reset_in_ready%0d", d), 64'(in_ready[d]), 64'd1);
      @(posedge clk); #1;

      // Directed vectors, expected {N,Z,C,V, result}.
      send(0, 32'h7F, 32'h01, 2'b00, 1'b0, 1'b1, {4'b1001, 32'h80}, 1'b1);
      send(0, 32'h05, 32'h07, 2'b01, 1'b0, 1'b1, {4'b1000, 32'hFE}, 1'b1);
      send(0, 32'h10, 32'h10, 2'b01, 1'b0, 1'b1, {4'b0110, 32'h00}, 1'b1);
      send(0, 32'hFF, 32'h00, 2'b10, 1'b1, 1'b1, {4'b0110, 32'h00}, 1'b1);
      send(0, 32'h80, 32'h01, 2'b11, 1'b1, 1'b1, {4'b0011, 32'h7F}, 1'b1);
      send(0, 32'hFF, 32'h01, 2'b00, 1'b1, 1'b1, {4'b0110, 32'h00}, 1'b1);
      in_valid[0] = 1'b0;
      send(1, 32'h7FFF_FFFF, 32'h1, 2'b00, 1'b0, 1'b1, {4'b1001, 32'h8000_0000}, 1'b1);
      send(1, 32'h0, 32'h1, 2'b01, 1'b0, 1'b1, {4'b1000, 32'hFFFF_FFFF}, 1'b1);
      in_valid[1] = 1'b0;
      repeat (6) @(posedge clk);
      #1;

      // Back-to-back random streams, latency checked per beat.
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 8; i++) rand_send(d, 1'b1);
         in_valid[d] = 1'b0;
         repeat (6) @(posedge clk);
         #1;
      end

      // Full pipe, out_ready low for 5 cycles.
      fork
         begin
            for (int i = 0; i < 10; i++) rand_send(0, 1'b0);
            in_valid[0] = 1'b0;
         end
         begin
            repeat (4) @(posedge clk);
            #1 out_ready[0] = 1'b0;
            repeat (5) @(posedge clk);
            #1 out_ready[0] = 1'b1;
         end
      join

      // Random backpressure on the wide instance.
      fork
         begin
            for (int i = 0; i < 20; i++) rand_send(1, 1'b0);
            in_valid[1] = 1'b0;
         end
         begin
            for (int i = 0; i < 30; i++) begin
               out_ready[1] = 1'($urandom_range(0, 1));
               @(posedge clk); #1;
            end
            out_ready[1] = 1'b1;
         end
      join
      repeat (10) @(posedge clk);
      #1;
      chk("drain0", 64'(q0.size()), 64'd0);
      chk("drain1", 64'(q1.size()), 64'd0);

      reset_with_inflight(0);
      repeat (6) @(posedge clk);
      #1;
      reset_with_inflight(1);
      repeat (8) @(posedge clk);
      #1;
      chk("final_drain0", 64'(q0.size()), 64'd0);
      chk("final_drain1", 64'(q1.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Parametrised, pipelined two's-complement adder/subtractor with carry-in, a valid/ready handshake and NZCV status flags. Operands are split into CHUNK-bit slices. Each pipeline stage resolves one slice and registers the carry into the next stage, so WIDTH scales without lengthening the critical path. The block is the arithmetic unit for the datapath, replacing the fixed 4-bit ripple add/sub.

## Interface
- WIDTH, 8: operand/result width in bits; must be a multiple of CHUNK, otherwise elaboration fails.
- CHUNK, 4: bits resolved per pipeline stage. STAGES = WIDTH/CHUNK.
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  2  00 ADD (a+b), 01 SUB (a-b), 10 ADC (a+b+cin), 11 SBC (a+~b+cin)
- cin  in  1  carry-in for ADC/SBC; ignored for ADD/SUB
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  sum/difference mod 2^WIDTH
- flag_n  out  1  result[WIDTH-1]
- flag_z  out  1  result == 0
- flag_c  out  1  carry out of MSB; for subtract, 1 = no borrow
- flag_v  out  1  signed overflow: operand-sign rule on a and effective b (~b for SUB/SBC)

## Operation
- Effective operand: b_eff = b for ADD/ADC, ~b for SUB/SBC.
- Carry-in to slice 0: 0 for ADD, 1 for SUB, cin for ADC/SBC.
- Stage k (0..STAGES-1) adds slice k of a and b_eff plus the registered carry from stage k-1. It registers the slice sum, the carry, and the not-yet-consumed upper slices of a and b_eff, plus a valid bit.
- Completed lower slices travel with the beat; every stage carries a full WIDTH-bit partial result.
- The last stage registers result and all four flags together with out_valid.
- flag_v = (a[MSB] == b_eff[MSB]) && (result[MSB] != a[MSB]).
- Global stall: adv = !out_valid || out_ready. All stage registers update only when adv = 1. in_ready = adv.
- Bubbles are not compressed; valid bits shift with the data.
- Input accepted when in_valid && in_ready. Output consumed when out_valid && out_ready.
- While out_valid && !out_ready, result and flags hold stable.
- Reset clears every stage valid bit and drives result, flag_n/z/c/v and out_valid to 0. rst takes priority over adv.
- Reset mid-operation discards all in-flight beats; no output for them appears after rst deasserts.
- in_ready is 1 in the cycle after reset deasserts.

## Timing
- Latency: a beat accepted at edge T appears on out_valid after edge T+STAGES, i.e. STAGES cycles with out_ready held high.
- Throughput: one beat per cycle with no backpressure.
- in_ready depends combinationally on out_ready and the registered out_valid only. There is no path from in_valid to in_ready.
- Outputs are registered; no combinational input-to-output path other than out_ready to in_ready.
- Simultaneous accept and consume in the same cycle is legal and keeps full throughput.

## Structure
- Shared package/include holds the op encodings (OP_ADD, OP_SUB, OP_ADC, OP_SBC) and the flag bit order {N,Z,C,V}.
- One sub-module, addsub_slice: combinational CHUNK-bit ripple adder (ci, a, b -> s, co) built from per-bit full-add equations. It is instantiated once per stage by a generate loop.
- Top level holds the stage registers, b_eff/carry-in selection, stall logic and flag generation.

## Test plan
(WIDTH=8, CHUNK=4, out_ready=1 unless stated.)
- ADD 0x7F+0x01 -> result 0x80, N=1 Z=0 C=0 V=1, out_valid exactly 2 cycles after accept.
- SUB 0x05-0x07 -> 0xFE, N=1 C=0 V=0. SUB 0x10-0x10 -> 0x00, Z=1 C=1.
- ADC 0xFF+0x00, cin=1 -> 0x00, Z=1 C=1 V=0. SBC 0x80-0x01, cin=1 -> 0x7F, C=1 V=1.
- Back-to-back stream of 8 random ops -> 8 results on consecutive cycles, in order, matching the reference model.
- Hold out_ready=0 for 5 cycles with the pipe full -> in_ready=0, result/flags stable. After release, no beat is lost or duplicated.
- Assert rst for 1 cycle with 2 beats in flight -> out_valid=0 and all flags/result 0 next cycle, no stale output afterward. Repeat with WIDTH=32, CHUNK=8: latency 4.
